data_memory_2p: RTL and testbench

DATA_MEMORY_2P -- requirements
Module: data_memory_2p

---
 rtl/data_memory_2p.sv | 123 ++++++++++++
 tb/tb_data_memory_2p.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_2p.sv
// Two-port (1W/1R) byte-writable data memory with a post-reset zero sweep.
// Define DATA_MEMORY_2P_OUTREG_EN to add a second output register (read latency 2).
//
// state | meaning
// CLEAR | sweeping zeros into every word, requests ignored, busy high
// READY | normal read/write service
module data_memory_2p #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 10,
  parameter int RDW_MODE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   write_adr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd,
  input  logic [ADDR_W-1:0]   read_adr,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   sweep_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   old_word, merged_word, rd_word, mem_wdata;
  logic [ADDR_W-1:0]   mem_adr;
  logic                mem_we, rd_fire;
  logic [DATA_W-1:0]   dout_s1;
  logic                valid_s1;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_adr   = write_adr;
    mem_wdata = merged_word;
    rd_fire   = 1'b0;
    busy      = 1'b0;
    case (state)
      CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_adr   = sweep_cnt;
        mem_wdata = '0;
        if (&sweep_cnt) state_nxt = READY;
      end
      READY: begin
        mem_we  = wr;
        rd_fire = rd;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              sweep_cnt <= '0;
    else if (state == CLEAR) sweep_cnt <= sweep_cnt + 1'b1;
  end

  // Array has no reset; the sweep defines every word before READY.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_adr] <= mem_wdata;
  end

  assign old_word = mem[write_adr];

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) merged_word[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  // New-data mode forwards the merged word on a same-address collision.
  always_comb begin
    rd_word = mem[read_adr];
    if (RDW_MODE == 1 && wr && (write_adr == read_adr)) rd_word = merged_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_s1  <= '0;
      valid_s1 <= 1'b0;
    end else begin
      valid_s1 <= rd_fire;
      if (rd_fire) dout_s1 <= rd_word;
    end
  end

`ifdef DATA_MEMORY_2P_OUTREG_EN
  logic [DATA_W-1:0] dout_s2;
  logic              valid_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_s2  <= '0;
      valid_s2 <= 1'b0;
    end else begin
      valid_s2 <= valid_s1;
      if (valid_s1) dout_s2 <= dout_s1;
    end
  end

  assign data_out = dout_s2;
  assign rd_valid = valid_s2;
`else
  assign data_out = dout_s1;
  assign rd_valid = valid_s1;
`endif

endmodule

// File: tb/tb_data_memory_2p.sv
// Directed bench for data_memory_2p: two instances (new-data and old-data
// read-during-write) driven by the same stimulus, ADDR_W = 4.
module tb_data_memory_2p;

`ifdef DATA_MEMORY_2P_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n, wr, rd;
  logic [3:0]  write_adr, read_adr;
  logic [63:0] data_in;
  logic [7:0]  wr_be;
  logic [63:0] dout1, dout0;
  logic        val1, val0, busy1, busy0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_memory_2p #(.DATA_W(64), .ADDR_W(4), .RDW_MODE(1)) u_new (
    .clk(clk), .rst_n(rst_n), .wr(wr), .write_adr(write_adr), .data_in(data_in),
    .wr_be(wr_be), .rd(rd), .read_adr(read_adr), .data_out(dout1),
    .rd_valid(val1), .busy(busy1)
  );

  data_memory_2p #(.DATA_W(64), .ADDR_W(4), .RDW_MODE(0)) u_old (
    .clk(clk), .rst_n(rst_n), .wr(wr), .write_adr(write_adr), .data_in(data_in),
    .wr_be(wr_be), .rd(rd), .read_adr(read_adr), .data_out(dout0),
    .rd_valid(val0), .busy(busy0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy1 === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
    wr = 1'b1; write_adr = a; data_in = d; wr_be = be;
    step();
    wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a,
                        input logic [63:0] e1, input logic [63:0] e0);
    rd = 1'b1; read_adr = a;
    step();
    rd = 1'b0;
    repeat (LAT - 1) step();
    chk({tag, "_valid"}, 64'(val1), 64'd1);
    chk({tag, "_new"}, dout1, e1);
    chk({tag, "_old"}, dout0, e0);
    step();
    chk({tag, "_pulse"}, 64'(val1), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic rv;
    logic [4:0] v;

    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; write_adr = '0; read_adr = '0;
    data_in = '0; wr_be = '0;
    step(); step();
    chk("rst_busy_new", 64'(busy1), 64'd1);
    chk("rst_busy_old", 64'(busy0), 64'd1);
    chk("rst_valid", 64'(val1), 64'd0);
    chk("rst_dout_new", dout1, 64'd0);
    chk("rst_dout_old", dout0, 64'd0);

    // Requests held high through the whole sweep must be ignored.
    rst_n = 1'b1;
    wr = 1'b1; write_adr = 4'd2; data_in = 64'hBEEF; wr_be = 8'hFF;
    rd = 1'b1; read_adr = 4'd2;
    n = 0; rv = 1'b0;
    while (busy1 === 1'b1 && n < 40) begin
      n++;
      rv = rv | val1 | val0;
      step();
    end
    wr = 1'b0; rd = 1'b0;
    chk("clear_len", 64'(n), 64'd16);
    chk("valid_during_clear", 64'(rv | val1), 64'd0);
    chk("busy_old_after_clear", 64'(busy0), 64'd0);

    for (int a = 0; a < 16; a++) rd_chk("zero_after_clear", 4'(a), 64'd0, 64'd0);

    do_write(4'd5, 64'h1122334455667788, 8'hFF);
    do_write(4'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    do_write(4'd6, 64'h5555555555555555, 8'h00);
    rd_chk("byte_en", 4'd5, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA);
    rd_chk("be_zero", 4'd6, 64'd0, 64'd0);

    do_write(4'd7, 64'h1, 8'hFF);
    wr = 1'b1; write_adr = 4'd7; data_in = 64'h2; wr_be = 8'hFF;
    rd = 1'b1; read_adr = 4'd7;
    step();
    wr = 1'b0; rd = 1'b0;
    repeat (LAT - 1) step();
    chk("rdw_full_new", dout1, 64'h2);
    chk("rdw_full_old", dout0, 64'h1);
    step();
    rd_chk("rdw_full_after", 4'd7, 64'h2, 64'h2);

    do_write(4'd8, 64'h1111, 8'hFF);
    wr = 1'b1; write_adr = 4'd8; data_in = 64'h2222; wr_be = 8'h01;
    rd = 1'b1; read_adr = 4'd8;
    step();
    wr = 1'b0; rd = 1'b0;
    repeat (LAT - 1) step();
    chk("rdw_part_new", dout1, 64'h1122);
    chk("rdw_part_old", dout0, 64'h1111);
    step();
    rd_chk("rdw_part_after", 4'd8, 64'h1122, 64'h1122);

    wr = 1'b1; write_adr = 4'd9; data_in = 64'h99; wr_be = 8'hFF;
    rd = 1'b1; read_adr = 4'd5;
    step();
    wr = 1'b0; rd = 1'b0;
    repeat (LAT - 1) step();
    chk("indep_new", dout1, 64'h11223344AAAAAAAA);
    chk("indep_old", dout0, 64'h11223344AAAAAAAA);
    step();
    rd_chk("indep_after", 4'd9, 64'h99, 64'h99);

    do_write(4'd0, 64'hA0, 8'hFF);
    do_write(4'd1, 64'hA1, 8'hFF);
    do_write(4'd2, 64'hA2, 8'hFF);
    rd = 1'b1; read_adr = 4'd0; step(); v[4] = val1;
    read_adr = 4'd1; step(); v[3] = val1;
    read_adr = 4'd2; step(); v[2] = val1;
    rd = 1'b0; step(); v[1] = val1;
    step(); v[0] = val1;
    chk("latency_valid_seq", 64'(v), (LAT == 1) ? 64'b11100 : 64'b01110);
    step();
    chk("hold_data", dout1, 64'hA2);

    rst_n = 1'b0; step(); rst_n = 1'b1;
    repeat (4) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midclear_busy", 64'(busy1), 64'd1);
    wait_clear(n);
    chk("midclear_restart_len", 64'(n), 64'd16);

    do_write(4'd3, 64'hDEAD, 8'hFF);
    rd_chk("dead_wr", 4'd3, 64'hDEAD, 64'hDEAD);
    rst_n = 1'b0;
    wr = 1'b1; write_adr = 4'd4; data_in = 64'h44; wr_be = 8'hFF;
    rd = 1'b1; read_adr = 4'd3;
    step();
    rst_n = 1'b1; wr = 1'b0; rd = 1'b0;
    chk("ready_rst_busy", 64'(busy1), 64'd1);
    chk("ready_rst_valid", 64'(val1), 64'd0);
    chk("ready_rst_dout_new", dout1, 64'd0);
    chk("ready_rst_dout_old", dout0, 64'd0);
    wait_clear(n);
    chk("ready_rst_len", 64'(n), 64'd16);
    rd_chk("addr3_cleared", 4'd3, 64'd0, 64'd0);
    rd_chk("addr4_cleared", 4'd4, 64'd0, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
